vga_sync_receiver: RTL and testbench
====================================

Name: vga_sync_receiver

Overview:
- Sink side of the VGA timing interface: takes hsync, vsync, video-enable and 12-bit RGB from a VGA timing source and recovers per-pixel coordinates.
- Measures line and frame totals and reports lock against the expected 640x480 timing.
- Sits in front of capture/measurement logic, such as the scope trace buffer and self-test of the sync generator, so downstream blocks consume (x, y, rgb) with a validity flag.

Parameters:
- H_TOTAL, 800, expected clocks per line (hsync leading edge to next leading edge)
- V_TOTAL, 525, expected lines per frame (vsync leading edge to next leading edge)
- SYNC_ACTIVE_HIGH, 1, 1: sync asserted when input high; 0: asserted when input low
- LOCK_FRAMES, 2, consecutive good frames required to enter LOCKED (range 1..15)

Ports:
- clk  in  1  pixel clock
- rst  in  1  reset, asynchronous, active-high
- hsync  in  1  horizontal sync from source
- vsync  in  1  vertical sync from source
- de  in  1  video enable (source's display-area flag)
- rgb_in  in  12  pixel colour
- pixel_valid  out  1  x/y/rgb_out describe a displayed pixel this cycle
- x  out  10  recovered column of current pixel
- y  out  10  recovered row of current pixel
- rgb_out  out  12  registered pixel colour, forced 0 when pixel_valid=0
- frame_start  out  1  one-cycle pulse on each registered vsync leading edge
- h_total  out  11  last measured line length in clocks
- v_total  out  11  last measured frame length in lines
- locked  out  1  high in LOCKED state
- timing_error  out  1  one-cycle pulse on loss of lock

Behaviour:
- Input stage: hsync, vsync, de and rgb_in are all registered once (hs_q, vs_q, de_q, rgb_q). Sync is asserted when hs_q == SYNC_ACTIVE_HIGH.
- Leading edge: asserted now, deasserted in the previous registered cycle. Both edge detectors reset to "deasserted".
- Output latency: exactly 2 clk from an input sample to the pixel_valid/x/y/rgb_out that describe it.
- hcnt (11b): increments every cycle, saturating at 2047.
  - On an hsync leading edge: h_total <= hcnt+1, hcnt <= 0, hvalid <= 1.
  - h_total updates only when hvalid was already 1, so the first edge after reset is not a measurement.
- lcnt (11b): increments on each hsync leading edge, saturating at 2047.
  - On a vsync leading edge: v_total <= lcnt, lcnt <= 0.
  - If both edges fall in the same cycle, the hsync is counted into the new frame (lcnt <= 1).
- x: reset to 0 on an hsync leading edge; increments after each de_q cycle; wraps 1023->0.
- y: reset to 0 on a vsync leading edge; increments on each de_q falling edge; wraps 1023->0.
- Same-cycle x/y events: the reset wins over the increment.
- Line check: line_bad is sticky per frame and set when either:
  - an hsync leading edge occurs with hvalid=1 and hcnt+1 != H_TOTAL, or
  - hcnt reaches 2*H_TOTAL (timeout).
  - line_bad clears on a vsync leading edge after that edge's frame is judged.
- Frame judgement: at a vsync leading edge the frame just ended is good iff line_bad==0 and lcnt==V_TOTAL (the hsync-in-same-cycle case is judged as not part of the ended frame).
- Lock FSM (reset state SEARCH, good-frame count gcnt 4b):
  - SEARCH: on a vsync leading edge -> CHECK, gcnt=0. The partial frame is not judged.
  - CHECK: at each vsync leading edge, a good frame increments gcnt; reaching LOCK_FRAMES -> LOCKED. A bad frame sets gcnt=0 and stays in CHECK.
  - LOCKED: a bad frame at a vsync leading edge, or a timeout mid-frame -> SEARCH, with a timing_error pulse in the same cycle as the transition.
  - A timeout in CHECK -> SEARCH, with no timing_error.
- Reset values:
  - All outputs 0: pixel_valid, x, y, rgb_out, frame_start, h_total, v_total, locked, timing_error.
  - Internal state: hvalid=0, line_bad=0, FSM in SEARCH.
- Mid-operation reset returns everything to reset values immediately, with no partial measurement kept.
- Coordinates and rgb_out are produced regardless of lock state. Consumers gate on locked.

Test Plan:
- Standard 640x480 source (800x525, sync high in retrace, default params), 3 frames -> locked rises at the 3rd vsync leading edge (2 good frames after the first), h_total=800, v_total=525, timing_error never pulses.
- Same stream, first visible pixel -> pixel_valid=1 with x=0, y=0, rgb_out=rgb_in driven 2 clk earlier; last pixel x=639, y=479; rgb_out=0 whenever pixel_valid=0.
- Once locked, lengthen one line to 801 clocks -> h_total=801, and at the next vsync leading edge locked falls, timing_error pulses once, FSM in SEARCH, relock after 3 further vsync edges.
- Once locked, hold hsync deasserted for 1600 clocks -> timeout, locked=0 and a timing_error pulse at hcnt=1600, no lock until a new good sequence.
- Frame with 524 lines -> v_total=524, gcnt reset, locked not reached until 2 consecutive 525-line frames follow.
- Assert rst for 1 cycle mid-frame while locked -> all outputs 0 asynchronously, first post-reset hsync edge does not update h_total, relock after 3 vsync edges.

Source files
------------

// File: rtl/vga_sync_receiver.sv
// VGA timing sink: registers the incoming sync/DE/RGB, recovers pixel coordinates,
// measures line/frame totals and tracks lock against the expected raster.
module vga_sync_receiver #(
    parameter int H_TOTAL          = 800,
    parameter int V_TOTAL          = 525,
    parameter bit SYNC_ACTIVE_HIGH = 1'b1,
    parameter int LOCK_FRAMES      = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hsync,
    input  logic        vsync,
    input  logic        de,
    input  logic [11:0] rgb_in,
    output logic        pixel_valid,
    output logic [9:0]  x,
    output logic [9:0]  y,
    output logic [11:0] rgb_out,
    output logic        frame_start,
    output logic [10:0] h_total,
    output logic [10:0] v_total,
    output logic        locked,
    output logic        timing_error,
    output logic [1:0]  state_dbg
);

    // Output handshake: pixel_valid qualifies x/y/rgb_out for exactly one cycle;
    // there is no ready, the consumer must take every valid pixel.

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_CHECK  = 2'd1,
        ST_LOCKED = 2'd2
    } lock_state_e;

    localparam logic [10:0] H_TOT      = 11'(H_TOTAL);
    localparam logic [10:0] V_TOT      = 11'(V_TOTAL);
    localparam logic [10:0] H_TMO_M1   = 11'(2 * H_TOTAL - 1);
    localparam logic [10:0] CNT_MAX    = 11'h7FF;
    localparam logic [3:0]  LOCK_N     = 4'(LOCK_FRAMES);

    logic        hs_q, vs_q, de_q;
    logic [11:0] rgb_q;
    logic        hs_prev_q, vs_prev_q, de_prev_q;

    logic [10:0] hcnt_q, hcnt_d;
    logic [10:0] lcnt_q, lcnt_d;
    logic        hvalid_q;
    logic        line_bad_q, line_bad_d;
    logic [9:0]  xcnt_q, xcnt_d;
    logic [9:0]  ycnt_q, ycnt_d;

    logic        pixel_valid_q;
    logic [9:0]  x_q, y_q;
    logic [11:0] rgb_out_q;
    logic        frame_start_q;
    logic [10:0] h_total_q, v_total_q;

    lock_state_e state_q;
    logic [3:0]  gcnt_q;
    logic        locked_q, timing_error_q;

    logic        hs_on, vs_on, h_lead, v_lead, de_fall;
    logic [10:0] h_len;
    logic        h_bad, timeout, frame_good;

    always_comb begin
        hs_on      = (hs_q == SYNC_ACTIVE_HIGH);
        vs_on      = (vs_q == SYNC_ACTIVE_HIGH);
        h_lead     = hs_on && !hs_prev_q;
        v_lead     = vs_on && !vs_prev_q;
        de_fall    = !de_q && de_prev_q;
        h_len      = hcnt_q + 11'd1;
        h_bad      = h_lead && hvalid_q && (h_len != H_TOT);
        // Fires once per stalled line: the counter keeps climbing past the limit.
        timeout    = (hcnt_q == H_TMO_M1) && !h_lead;
        frame_good = !line_bad_q && (lcnt_q == V_TOT);
    end

    always_comb begin
        hcnt_d = hcnt_q;
        if (h_lead) begin
            hcnt_d = 11'd0;
        end else if (hcnt_q != CNT_MAX) begin
            hcnt_d = hcnt_q + 11'd1;
        end

        lcnt_d = lcnt_q;
        if (v_lead) begin
            // An hsync edge in the same cycle opens the first line of the new frame.
            lcnt_d = h_lead ? 11'd1 : 11'd0;
        end else if (h_lead && (lcnt_q != CNT_MAX)) begin
            lcnt_d = lcnt_q + 11'd1;
        end

        line_bad_d = line_bad_q | h_bad | timeout;
        if (v_lead) begin
            line_bad_d = h_bad | timeout;
        end

        xcnt_d = xcnt_q;
        if (h_lead) begin
            xcnt_d = 10'd0;
        end else if (de_q) begin
            xcnt_d = xcnt_q + 10'd1;
        end

        ycnt_d = ycnt_q;
        if (v_lead) begin
            ycnt_d = 10'd0;
        end else if (de_fall) begin
            ycnt_d = ycnt_q + 10'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hs_q          <= !SYNC_ACTIVE_HIGH;
            vs_q          <= !SYNC_ACTIVE_HIGH;
            de_q          <= 1'b0;
            rgb_q         <= 12'd0;
            hs_prev_q     <= 1'b0;
            vs_prev_q     <= 1'b0;
            de_prev_q     <= 1'b0;
            hcnt_q        <= 11'd0;
            lcnt_q        <= 11'd0;
            hvalid_q      <= 1'b0;
            line_bad_q    <= 1'b0;
            xcnt_q        <= 10'd0;
            ycnt_q        <= 10'd0;
            pixel_valid_q <= 1'b0;
            x_q           <= 10'd0;
            y_q           <= 10'd0;
            rgb_out_q     <= 12'd0;
            frame_start_q <= 1'b0;
            h_total_q     <= 11'd0;
            v_total_q     <= 11'd0;
        end else begin
            hs_q          <= hsync;
            vs_q          <= vsync;
            de_q          <= de;
            rgb_q         <= rgb_in;
            hs_prev_q     <= hs_on;
            vs_prev_q     <= vs_on;
            de_prev_q     <= de_q;
            hcnt_q        <= hcnt_d;
            lcnt_q        <= lcnt_d;
            line_bad_q    <= line_bad_d;
            xcnt_q        <= xcnt_d;
            ycnt_q        <= ycnt_d;
            if (h_lead) begin
                hvalid_q <= 1'b1;
            end
            // The first edge after reset only starts a line, it measures nothing.
            if (h_lead && hvalid_q) begin
                h_total_q <= h_len;
            end
            if (v_lead) begin
                v_total_q <= lcnt_q;
            end
            pixel_valid_q <= de_q;
            x_q           <= xcnt_q;
            y_q           <= ycnt_q;
            rgb_out_q     <= de_q ? rgb_q : 12'd0;
            frame_start_q <= v_lead;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_SEARCH;
            gcnt_q         <= 4'd0;
            locked_q       <= 1'b0;
            timing_error_q <= 1'b0;
        end else begin
            timing_error_q <= 1'b0;
            case (state_q)
                ST_SEARCH: begin
                    // The partial frame seen on entry is never judged.
                    if (v_lead) begin
                        state_q <= ST_CHECK;
                        gcnt_q  <= 4'd0;
                    end
                end
                ST_CHECK: begin
                    if (timeout) begin
                        state_q <= ST_SEARCH;
                    end else if (v_lead) begin
                        if (frame_good) begin
                            gcnt_q <= gcnt_q + 4'd1;
                            if (gcnt_q + 4'd1 == LOCK_N) begin
                                state_q  <= ST_LOCKED;
                                locked_q <= 1'b1;
                            end
                        end else begin
                            gcnt_q <= 4'd0;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (timeout || (v_lead && !frame_good)) begin
                        state_q        <= ST_SEARCH;
                        locked_q       <= 1'b0;
                        timing_error_q <= 1'b1;
                    end
                end
                default: begin
                    state_q  <= ST_SEARCH;
                    locked_q <= 1'b0;
                end
            endcase
        end
    end

    assign pixel_valid  = pixel_valid_q;
    assign x            = x_q;
    assign y            = y_q;
    assign rgb_out      = rgb_out_q;
    assign frame_start  = frame_start_q;
    assign h_total      = h_total_q;
    assign v_total      = v_total_q;
    assign locked       = locked_q;
    assign timing_error = timing_error_q;
    assign state_dbg    = state_q;

endmodule

// File: tb/tb_vga_sync_receiver.sv
// Bench for vga_sync_receiver on a scaled 64x20 raster: random frames and faults,
// expectations from a sample-level reference model, checked by a decoupled monitor.
module tb_vga_sync_receiver;

    localparam int HT = 64;
    localparam int VT = 20;
    localparam int LF = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        hsync = 1'b0, vsync = 1'b0, de = 1'b0;
    logic [11:0] rgb_in = 12'd0;
    logic        pixel_valid, frame_start, locked, timing_error;
    logic [9:0]  x, y;
    logic [11:0] rgb_out;
    logic [10:0] h_total, v_total;
    logic [1:0]  state_dbg;

    vga_sync_receiver #(
        .H_TOTAL(HT), .V_TOTAL(VT), .SYNC_ACTIVE_HIGH(1'b1), .LOCK_FRAMES(LF)
    ) dut (
        .clk(clk), .rst(rst), .hsync(hsync), .vsync(vsync), .de(de), .rgb_in(rgb_in),
        .pixel_valid(pixel_valid), .x(x), .y(y), .rgb_out(rgb_out),
        .frame_start(frame_start), .h_total(h_total), .v_total(v_total),
        .locked(locked), .timing_error(timing_error), .state_dbg(state_dbg)
    );

    // clock / cycle counter
    int cyc = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // expected queues: {cycle, payload}
    logic [63:0] pix_q[$];
    logic [63:0] hq[$];
    logic [63:0] fq[$];
    logic [31:0] tq[$];

    function automatic logic [63:0] pk_pix(int c, int xv, int yv, logic [11:0] col);
        return {32'(c), 10'(xv), 10'(yv), col};
    endfunction
    function automatic logic [63:0] pk_h(int c, int hv);
        return {32'(c), 21'd0, 11'(hv)};
    endfunction
    function automatic logic [63:0] pk_frame(int c, bit te, bit lk, int st, int vt);
        return {32'(c), 17'd0, te, lk, 2'(st), 11'(vt)};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string nm, input string what);
        checks++;
        errors++;
        $display("FAIL %s: %s (cycle %0d)", nm, what, cyc);
    endtask

    // reference model: raster rules applied to each input sample
    bit m_hs_prev, m_vs_prev, m_de_prev, m_bad;
    int m_last_hlead, m_htotal, m_lines, m_x, m_y, m_state, m_gcnt;

    task automatic model_reset();
        m_hs_prev = 0; m_vs_prev = 0; m_de_prev = 0; m_bad = 0;
        m_last_hlead = -1; m_htotal = 0; m_lines = 0; m_x = 0; m_y = 0;
        m_state = 0; m_gcnt = 0;
        pix_q.delete(); hq.delete(); fq.delete(); tq.delete();
    endtask

    task automatic model_sample(input int d, input bit h, input bit v, input bit e,
                                input logic [11:0] c);
        bit hl, vl, fall, to, te, good;
        int st0, vt;
        hl = h && !m_hs_prev;
        vl = v && !m_vs_prev;
        fall = !e && m_de_prev;
        to = (m_last_hlead >= 0) && (d - m_last_hlead == 2 * HT) && !hl;
        st0 = m_state;
        te = 0;
        vt = 0;
        if (e) pix_q.push_back(pk_pix(d + 2, m_x, m_y, c));
        if (to) begin
            m_bad = 1;
            if (st0 == 2) begin
                if (vl) te = 1;
                else tq.push_back(32'(d + 2));
            end
            m_state = 0;
        end
        if (vl) begin
            if (!(to && st0 != 0)) begin
                if (st0 == 0) begin
                    m_state = 1;
                    m_gcnt = 0;
                end else begin
                    good = !m_bad && (m_lines == VT);
                    if (st0 == 1) begin
                        if (good) begin
                            m_gcnt++;
                            if (m_gcnt == LF) m_state = 2;
                        end else m_gcnt = 0;
                    end else if (!good) begin
                        m_state = 0;
                        te = 1;
                    end
                end
            end
            m_bad = to;
            vt = m_lines;
            m_lines = 0;
        end
        if (hl) begin
            if (m_last_hlead >= 0) begin
                m_htotal = d - m_last_hlead;
                if (m_htotal != HT) m_bad = 1;
            end
            m_last_hlead = d;
            if (m_lines < 2047) m_lines++;
            hq.push_back(pk_h(d + 2, m_htotal));
        end
        if (vl) fq.push_back(pk_frame(d + 2, te, m_state == 2, m_state, vt));
        if (hl) m_x = 0;
        else if (e) m_x = (m_x + 1) % 1024;
        if (vl) m_y = 0;
        else if (fall) m_y = (m_y + 1) % 1024;
        m_hs_prev = h;
        m_vs_prev = v;
        m_de_prev = e;
    endtask

    // driver tasks
    task automatic drive(input bit h, input bit v, input bit e);
        logic [11:0] c;
        c = 12'($urandom);
        @(posedge clk);
        #1;
        hsync = h; vsync = v; de = e; rgb_in = c;
        model_sample(cyc, h, v, e, c);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        hsync = 0; vsync = 0; de = 0; rgb_in = 12'd0;
        #1;
        chk("reset_outputs", {pixel_valid, x, y, rgb_out, frame_start},
            64'd0);
        chk("reset_totals", {h_total, v_total, locked, timing_error, state_dbg}, 64'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_sample(cyc, 0, 0, 0, 12'd0);
    endtask

    // one raster frame starting on its vsync line; optional long line, stall, reset
    task automatic send_frame(input int nl, input int long_idx, input int long_len,
                              input int stall_idx, input int stall_len, input int rst_idx);
        int aw, ah, len;
        aw = $urandom_range(8, 48);
        ah = $urandom_range(4, 12);
        for (int l = 0; l < nl; l++) begin
            len = (l == long_idx) ? long_len : HT;
            for (int hc = 0; hc < len; hc++) begin
                if (l == rst_idx && hc == 30) begin
                    do_reset();
                    return;
                end
                drive(hc >= 52 && hc < 60, l < 2, l >= 4 && l < 4 + ah && hc < aw);
            end
            if (l == stall_idx) repeat (stall_len) drive(0, l < 2, 0);
        end
    endtask

    task automatic normal_frames(input int n);
        repeat (n) send_frame(VT, -1, 0, -1, 0, -1);
    endtask

    // monitor / scoreboard
    bit prev_locked = 0;
    always @(negedge clk) begin : monitor
        logic [63:0] e;
        if (rst) begin
            prev_locked = 0;
        end else begin
            if (pixel_valid) begin
                if (pix_q.size() == 0) fail_now("pixel", "unexpected pixel_valid");
                else begin
                    e = pix_q.pop_front();
                    chk("pixel", pk_pix(cyc, x, y, rgb_out), e);
                end
            end else begin
                chk("rgb_blank", 64'(rgb_out), 64'd0);
            end
            if (hq.size() > 0 && hq[0][63:32] == 32'(cyc)) begin
                e = hq.pop_front();
                chk("h_total", pk_h(cyc, 32'(h_total)), e);
            end
            if (frame_start) begin
                if (fq.size() == 0) fail_now("frame_start", "unexpected pulse");
                else begin
                    e = fq.pop_front();
                    chk("frame", pk_frame(cyc, timing_error, locked, 32'(state_dbg),
                        32'(v_total)), e);
                end
            end else if (timing_error) begin
                if (tq.size() == 0) fail_now("timing_error", "unexpected pulse");
                else chk("timeout_err", {32'(cyc), 31'd0, locked}, {tq.pop_front(), 32'd0});
            end
            if (locked != prev_locked && !frame_start && !timing_error)
                fail_now("locked", "changed without a frame or timeout event");
            prev_locked = locked;
            while (pix_q.size() > 0 && pix_q[0][63:32] <= 32'(cyc)) begin
                e = pix_q.pop_front();
                fail_now("pixel", $sformatf("missing pixel expected %h", e));
            end
            while (hq.size() > 0 && hq[0][63:32] <= 32'(cyc)) begin
                e = hq.pop_front();
                fail_now("h_total", $sformatf("missed check expected %h", e));
            end
            while (fq.size() > 0 && fq[0][63:32] <= 32'(cyc)) begin
                e = fq.pop_front();
                fail_now("frame_start", $sformatf("missing pulse expected %h", e));
            end
            while (tq.size() > 0 && tq[0] <= 32'(cyc)) begin
                fail_now("timeout_err", $sformatf("missing pulse at cycle %0d", tq.pop_front()));
            end
        end
    end

    // stimulus
    initial begin
        int kind;
        model_reset();
        repeat (2) @(posedge clk);
        do_reset();
        normal_frames(4);
        send_frame(VT, $urandom_range(5, 15), HT + 1, -1, 0, -1);
        normal_frames(4);
        send_frame(VT, -1, 0, $urandom_range(5, 15), 100, -1);
        normal_frames(4);
        send_frame(VT, -1, 0, -1, 0, 8);
        normal_frames(4);
        send_frame(VT - 1, -1, 0, -1, 0, -1);
        normal_frames(3);
        for (int i = 0; i < 8; i++) begin
            kind = $urandom_range(0, 5);
            case (kind)
                0: send_frame(VT, $urandom_range(3, 15), HT - 1 + 2 * $urandom_range(0, 1),
                              -1, 0, -1);
                1: send_frame(VT - 1 + 2 * $urandom_range(0, 1), -1, 0, -1, 0, -1);
                2: send_frame(VT, -1, 0, $urandom_range(3, 15), $urandom_range(40, 120), -1);
                default: send_frame(VT, -1, 0, -1, 0, -1);
            endcase
        end
        send_frame(3, -1, 0, -1, 0, -1);
        repeat (10) drive(0, 0, 0);
        repeat (3) @(posedge clk);
        #2;
        chk("pix_q_empty", 64'(pix_q.size()), 64'd0);
        chk("hq_empty", 64'(hq.size()), 64'd0);
        chk("fq_empty", 64'(fq.size()), 64'd0);
        chk("tq_empty", 64'(tq.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
